// File: rtl/inert_pkg.sv
// Shared register map, sample layout and bit-engine state encoding for the inertial sensor responder.
// Purely declarative: no logic, no latency, no flow control.
package inert_pkg;

   localparam logic [6:0] ADDR_INT_CFG  = 7'h0D;
   localparam logic [6:0] ADDR_WHO_AM_I = 7'h0F;
   localparam logic [6:0] ADDR_ACC_CFG  = 7'h10;
   localparam logic [6:0] ADDR_GYR_CFG  = 7'h11;
   localparam logic [6:0] ADDR_RND_CFG  = 7'h14;
   localparam logic [6:0] ADDR_ROLL_L   = 7'h24;
   localparam logic [6:0] ADDR_ROLL_H   = 7'h25;
   localparam logic [6:0] ADDR_YAW_L    = 7'h26;
   localparam logic [6:0] ADDR_YAW_H    = 7'h27;
   localparam logic [6:0] ADDR_AX_L     = 7'h28;
   localparam logic [6:0] ADDR_AX_H     = 7'h29;
   localparam logic [6:0] ADDR_AY_L     = 7'h2A;
   localparam logic [6:0] ADDR_AY_H     = 7'h2B;
   localparam logic [6:0] ADDR_AZ_L     = 7'h2C;
   localparam logic [6:0] ADDR_AZ_H     = 7'h2D;

   localparam int READ_BIT     = 15;
   localparam int SMPL_EN_BIT  = 1;

   localparam logic [7:0] INT_CFG_RST = 8'h00;
   localparam logic [7:0] ACC_CFG_RST = 8'h00;
   localparam logic [7:0] GYR_CFG_RST = 8'h00;
   localparam logic [7:0] RND_CFG_RST = 8'h00;

   typedef struct packed {
      logic [15:0] roll;
      logic [15:0] yaw;
      logic [15:0] ax;
      logic [15:0] ay;
      logic [15:0] az;
   } smpl_t;

   typedef enum logic {
      ENG_IDLE  = 1'b0,
      ENG_FRAME = 1'b1
   } eng_state_t;

endpackage

// File: rtl/inert_spi_bit_eng.sv
// SPI responder bit engine: synchronizes SS_n/SCLK/MOSI, counts rises, shifts the 16-bit frame, swaps in read data.
// Edges seen ~3 clk after the pins; no backpressure, the monarch owns timing (>=4 clk per SCLK phase).
module inert_spi_bit_eng
   import inert_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   input  logic [7:0]  load,
   output logic        MISO,
   output logic [7:0]  cmd_hi,
   output logic [15:0] frm_word,
   output logic        frm_ok,
   output logic        at_rd_load
);

   // [0],[1] metastability, [2] edge-detect history
   logic [2:0]  r_ss_sh;
   logic [2:0]  r_sclk_sh;
   logic [2:0]  r_mosi_sh;
   eng_state_t  r_state;
   eng_state_t  w_nxt_state;
   logic        r_armed;
   logic [4:0]  r_rcnt;
   logic [15:0] r_shft;
   logic        r_mosi_smpl;
   logic [7:0]  r_cmd_hi;

   logic w_ss_rise, w_ss_fall, w_sclk_rise, w_sclk_fall, w_start, w_in_frm;

   // SS_n history resets low so a select held low through reset can never look like a fresh fall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ss_sh   <= 3'b000;
         r_sclk_sh <= 3'b111;
         r_mosi_sh <= 3'b000;
      end else begin
         r_ss_sh   <= {r_ss_sh[1:0], SS_n};
         r_sclk_sh <= {r_sclk_sh[1:0], SCLK};
         r_mosi_sh <= {r_mosi_sh[1:0], MOSI};
      end
   end

   assign w_ss_rise   = ~r_ss_sh[2] &  r_ss_sh[1];
   assign w_ss_fall   =  r_ss_sh[2] & ~r_ss_sh[1];
   assign w_sclk_rise = ~r_sclk_sh[2] &  r_sclk_sh[1];
   assign w_sclk_fall =  r_sclk_sh[2] & ~r_sclk_sh[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ENG_IDLE;
      else        r_state <= w_nxt_state;
   end

   always_comb begin
      w_nxt_state = r_state;
      w_start     = 1'b0;
      case (r_state)
         ENG_IDLE: begin
            if (w_ss_fall && r_armed) begin
               w_nxt_state = ENG_FRAME;
               w_start     = 1'b1;
            end
         end
         ENG_FRAME: begin
            if (w_ss_rise) w_nxt_state = ENG_IDLE;
         end
         default: w_nxt_state = ENG_IDLE;
      endcase
   end

   assign w_in_frm   = (r_state == ENG_FRAME);
   assign frm_word   = {r_shft[14:0], r_mosi_smpl};
   assign frm_ok     = w_in_frm && w_ss_rise && (r_rcnt == 5'd16);
   assign at_rd_load = w_in_frm && w_sclk_fall && (r_rcnt == 5'd8) && frm_word[READ_BIT-8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed     <= 1'b0;
         r_rcnt      <= 5'd0;
         r_shft      <= 16'h0000;
         r_mosi_smpl <= 1'b0;
         r_cmd_hi    <= 8'h00;
      end else begin
         if (r_ss_sh[1]) r_armed <= 1'b1;
         if (w_start) begin
            r_rcnt <= 5'd0;
            r_shft <= 16'h0000;
         end else if (w_in_frm) begin
            if (w_sclk_rise) begin
               r_mosi_smpl <= r_mosi_sh[2];
               if (r_rcnt != 5'd16) r_rcnt <= r_rcnt + 5'd1;
            end else if (w_sclk_fall && (r_rcnt != 5'd0)) begin
               if (r_rcnt == 5'd8) r_cmd_hi <= frm_word[7:0];
               if (at_rd_load) r_shft <= {load, 8'h00};
               else            r_shft <= frm_word;
            end
         end
      end
   end

   assign MISO   = r_shft[15];
   assign cmd_hi = r_cmd_hi;

endmodule

// File: rtl/inert_spi_serf.sv
// Inertial sensor SPI responder: config registers, sample snapshot, read mux and data-ready interrupt.
// Writes land ~4 clk after SS_n rise; INT sets the clk after an accepted new_smpl; samples dropped while INT is high.
module inert_spi_serf
   import inert_pkg::*;
#(
   parameter logic [7:0] WHO_AM_I_VAL = 8'h6A
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        INT,
   input  logic        new_smpl,
   input  logic [15:0] roll_in,
   input  logic [15:0] yaw_in,
   input  logic [15:0] AX_in,
   input  logic [15:0] AY_in,
   input  logic [15:0] AZ_in,
   output logic [7:0]  int_cfg,
   output logic [7:0]  acc_cfg,
   output logic [7:0]  gyr_cfg,
   output logic [7:0]  rnd_cfg
);

   logic [7:0]  r_int_cfg, r_acc_cfg, r_gyr_cfg, r_rnd_cfg;
   smpl_t       r_snap;
   logic        r_int;

   logic [7:0]  w_load;
   logic [7:0]  w_cmd_hi;
   logic [15:0] w_frm_word;
   logic        w_frm_ok, w_at_rd_load;
   logic        w_wr, w_clr, w_int_kept, w_take;
   logic [6:0]  w_wr_addr;

   inert_spi_bit_eng u_bit_eng (
      .clk        (clk),
      .rst_n      (rst_n),
      .SS_n       (SS_n),
      .SCLK       (SCLK),
      .MOSI       (MOSI),
      .load       (w_load),
      .MISO       (MISO),
      .cmd_hi     (w_cmd_hi),
      .frm_word   (w_frm_word),
      .frm_ok     (w_frm_ok),
      .at_rd_load (w_at_rd_load)
   );

   // At the load strobe the low byte of frm_word is the command byte, so [6:0] is the address
   always_comb begin
      w_load = 8'h00;
      if (w_at_rd_load) begin
         case (w_frm_word[6:0])
            ADDR_WHO_AM_I: w_load = WHO_AM_I_VAL;
            ADDR_INT_CFG:  w_load = r_int_cfg;
            ADDR_ACC_CFG:  w_load = r_acc_cfg;
            ADDR_GYR_CFG:  w_load = r_gyr_cfg;
            ADDR_RND_CFG:  w_load = r_rnd_cfg;
            ADDR_ROLL_L:   w_load = r_snap.roll[7:0];
            ADDR_ROLL_H:   w_load = r_snap.roll[15:8];
            ADDR_YAW_L:    w_load = r_snap.yaw[7:0];
            ADDR_YAW_H:    w_load = r_snap.yaw[15:8];
            ADDR_AX_L:     w_load = r_snap.ax[7:0];
            ADDR_AX_H:     w_load = r_snap.ax[15:8];
            ADDR_AY_L:     w_load = r_snap.ay[7:0];
            ADDR_AY_H:     w_load = r_snap.ay[15:8];
            ADDR_AZ_L:     w_load = r_snap.az[7:0];
            ADDR_AZ_H:     w_load = r_snap.az[15:8];
            default:       w_load = 8'h00;
         endcase
      end
   end

   assign w_wr      = w_frm_ok && !w_frm_word[READ_BIT];
   assign w_wr_addr = w_frm_word[14:8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_int_cfg <= INT_CFG_RST;
         r_acc_cfg <= ACC_CFG_RST;
         r_gyr_cfg <= GYR_CFG_RST;
         r_rnd_cfg <= RND_CFG_RST;
      end else if (w_wr) begin
         case (w_wr_addr)
            ADDR_INT_CFG: r_int_cfg <= w_frm_word[7:0];
            ADDR_ACC_CFG: r_acc_cfg <= w_frm_word[7:0];
            ADDR_GYR_CFG: r_gyr_cfg <= w_frm_word[7:0];
            ADDR_RND_CFG: r_rnd_cfg <= w_frm_word[7:0];
            default: ;
         endcase
      end
   end

   // Clear first, then set: a sample arriving on the AZH commit cycle is taken and re-raises INT
   assign w_clr      = w_frm_ok && w_cmd_hi[7] && (w_cmd_hi[6:0] == ADDR_AZ_H);
   assign w_int_kept = r_int && !w_clr;
   assign w_take     = new_smpl && r_int_cfg[SMPL_EN_BIT] && !w_int_kept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_int  <= 1'b0;
         r_snap <= '0;
      end else begin
         r_int <= w_take || w_int_kept;
         if (w_take) r_snap <= '{roll: roll_in, yaw: yaw_in, ax: AX_in, ay: AY_in, az: AZ_in};
      end
   end

   assign INT     = r_int;
   assign int_cfg = r_int_cfg;
   assign acc_cfg = r_acc_cfg;
   assign gyr_cfg = r_gyr_cfg;
   assign rnd_cfg = r_rnd_cfg;

endmodule

// File: tb/tb_inert_spi_serf.sv
// Bench for inert_spi_serf: table-driven SPI frames with a read-response scoreboard plus hand-written corner sequences.
module tb_inert_spi_serf;

   localparam int HALF = 16;

   logic        clk = 1'b0;
   logic        rst_n, SS_n, SCLK, MOSI, new_smpl;
   logic [15:0] roll_in, yaw_in, AX_in, AY_in, AZ_in;
   logic        MISO, INT;
   logic [7:0]  int_cfg, acc_cfg, gyr_cfg, rnd_cfg;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] cmd;
      logic [7:0]  exp_rd;
      int          sel;
      logic [7:0]  exp_v;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] sb_q[$];

   always #5 clk = ~clk;

   inert_spi_serf dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .SCLK     (SCLK),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .INT      (INT),
      .new_smpl (new_smpl),
      .roll_in  (roll_in),
      .yaw_in   (yaw_in),
      .AX_in    (AX_in),
      .AY_in    (AY_in),
      .AZ_in    (AZ_in),
      .int_cfg  (int_cfg),
      .acc_cfg  (acc_cfg),
      .gyr_cfg  (gyr_cfg),
      .rnd_cfg  (rnd_cfg)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bit(input logic b, output logic so);
      SCLK = 1'b0;
      MOSI = b;
      clk_n(HALF);
      SCLK = 1'b1;
      so   = MISO;
      clk_n(HALF);
   endtask

   // Returns 4 clk after SS_n rise; smpl_commit pulses new_smpl on the commit clk
   task automatic spi_frame(input logic [15:0] cmd, input int nrise, input bit smpl_commit,
                            output logic [15:0] resp);
      logic so;
      resp = 16'h0000;
      SS_n = 1'b1;
      clk_n(4);
      SS_n = 1'b0;
      clk_n(HALF);
      for (int i = 0; i < nrise; i++) begin
         spi_bit(cmd[15-i], so);
         resp = {resp[14:0], so};
      end
      SS_n = 1'b1;
      clk_n(2);
      if (smpl_commit) new_smpl = 1'b1;
      clk_n(1);
      new_smpl = 1'b0;
      clk_n(1);
   endtask

   task automatic pulse_smpl();
      new_smpl = 1'b1;
      clk_n(1);
      new_smpl = 1'b0;
   endtask

   function automatic void add_vec(input logic [15:0] cmd, input logic [7:0] exp_rd,
                                   input int sel, input logic [7:0] exp_v);
      vec_t v;
      v.cmd = cmd; v.exp_rd = exp_rd; v.sel = sel; v.exp_v = exp_v;
      vecs.push_back(v);
   endfunction

   function automatic logic [7:0] reg_of(input int sel);
      case (sel)
         1: return int_cfg;
         2: return acc_cfg;
         3: return gyr_cfg;
         4: return rnd_cfg;
         5: return {7'd0, INT};
         default: return 8'h00;
      endcase
   endfunction

   task automatic pop_check(input string name, input logic [7:0] act);
      logic [7:0] e;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: got %h required queued expectation", name, act);
      end else begin
         e = sb_q.pop_front();
         check(name, {8'h00, act}, {8'h00, e});
      end
   endtask

   task automatic run_vecs();
      logic [15:0] resp;
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].cmd[15]) sb_q.push_back(vecs[i].exp_rd);
         spi_frame(vecs[i].cmd, 16, 1'b0, resp);
         if (vecs[i].cmd[15])
            pop_check($sformatf("rd_%h", vecs[i].cmd[14:8]), resp[7:0]);
         if (vecs[i].sel != 0)
            check($sformatf("reg%0d_after_%h", vecs[i].sel, vecs[i].cmd),
                  {8'h00, reg_of(vecs[i].sel)}, {8'h00, vecs[i].exp_v});
      end
      vecs.delete();
   endtask

   initial begin
      logic [15:0] resp;
      logic        so;
      logic [15:0] cmd;

      rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; new_smpl = 1'b0;
      roll_in = 16'h1111; yaw_in = 16'h0; AX_in = 16'h0; AY_in = 16'h0; AZ_in = 16'h0;
      clk_n(5);
      rst_n = 1'b1;
      clk_n(5);

      check("rst_INT", {15'd0, INT}, 16'h0);
      check("rst_MISO", {15'd0, MISO}, 16'h0);
      check("rst_int_cfg", {8'h00, int_cfg}, 16'h0);
      check("rst_acc_cfg", {8'h00, acc_cfg}, 16'h0);
      check("rst_gyr_cfg", {8'h00, gyr_cfg}, 16'h0);
      check("rst_rnd_cfg", {8'h00, rnd_cfg}, 16'h0);

      pulse_smpl();
      clk_n(2);
      check("smpl_gated_INT", {15'd0, INT}, 16'h0);

      add_vec(16'hA400, 8'h00, 0, 8'h00);
      add_vec(16'h0D02, 8'h00, 1, 8'h02);
      add_vec(16'h1053, 8'h00, 2, 8'h53);
      add_vec(16'h1150, 8'h00, 3, 8'h50);
      add_vec(16'h1460, 8'h00, 4, 8'h60);
      add_vec(16'h9000, 8'h53, 0, 8'h00);
      add_vec(16'h8F00, 8'h6A, 0, 8'h00);
      add_vec(16'hB300, 8'h00, 0, 8'h00);
      add_vec(16'h8D00, 8'h02, 0, 8'h00);
      add_vec(16'h0F55, 8'h00, 0, 8'h00);
      add_vec(16'h8F00, 8'h6A, 0, 8'h00);
      add_vec(16'h9100, 8'h50, 0, 8'h00);
      add_vec(16'h9400, 8'h60, 0, 8'h00);
      run_vecs();

      roll_in = 16'h1234; yaw_in = 16'h5678; AX_in = 16'h9ABC; AY_in = 16'hDEF0; AZ_in = 16'h0FED;
      check("pre_smpl_INT", {15'd0, INT}, 16'h0);
      pulse_smpl();
      check("smpl_INT_next_clk", {15'd0, INT}, 16'h1);

      add_vec(16'hA400, 8'h34, 5, 8'h01);
      add_vec(16'hA500, 8'h12, 5, 8'h01);
      add_vec(16'hA600, 8'h78, 5, 8'h01);
      add_vec(16'hA700, 8'h56, 5, 8'h01);
      add_vec(16'hA800, 8'hBC, 5, 8'h01);
      add_vec(16'hA900, 8'h9A, 5, 8'h01);
      add_vec(16'hAA00, 8'hF0, 5, 8'h01);
      add_vec(16'hAB00, 8'hDE, 5, 8'h01);
      add_vec(16'hAC00, 8'hED, 5, 8'h01);
      add_vec(16'hAD00, 8'h0F, 5, 8'h00);
      run_vecs();

      pulse_smpl();
      clk_n(1);
      check("reset_INT_again", {15'd0, INT}, 16'h1);
      roll_in = 16'hFFFF;
      pulse_smpl();
      add_vec(16'hA400, 8'h34, 5, 8'h01);
      run_vecs();

      spi_frame(16'h1077, 10, 1'b0, resp);
      check("abort_acc_cfg", {8'h00, acc_cfg}, 16'h0053);

      roll_in = 16'h4321; AZ_in = 16'hC3A5;
      sb_q.push_back(8'h0F);
      spi_frame(16'hAD00, 16, 1'b1, resp);
      pop_check("rd_2d_with_smpl", resp[7:0]);
      check("clr_and_set_INT", {15'd0, INT}, 16'h1);
      add_vec(16'hA400, 8'h21, 5, 8'h01);
      add_vec(16'hAD00, 8'hC3, 5, 8'h00);
      run_vecs();

      cmd = 16'h1199;
      SS_n = 1'b0;
      clk_n(HALF);
      for (int i = 0; i < 5; i++) spi_bit(cmd[15-i], so);
      rst_n = 1'b0;
      clk_n(3);
      rst_n = 1'b1;
      clk_n(3);
      for (int i = 0; i < 16; i++) spi_bit(cmd[15-i], so);
      SS_n = 1'b1;
      clk_n(4);
      check("midrst_gyr_cfg", {8'h00, gyr_cfg}, 16'h0000);
      check("midrst_acc_cfg", {8'h00, acc_cfg}, 16'h0000);
      check("midrst_MISO", {15'd0, MISO}, 16'h0);

      add_vec(16'h1122, 8'h00, 3, 8'h22);
      add_vec(16'hA400, 8'h00, 0, 8'h00);
      run_vecs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
